pwm_signal_generator: RTL and testbench

Programmable square-wave source for the frequency-counter design. It drives a 1-bit waveform whose high and low durations are set in system-clock cycles. It is the transmit-side counterpart of the input-capture measurement path. Self-test and board loopback use it to stimulate the capture block with known high/low/period values. It supports finite bursts, continuous output, glitch-free reconfiguration at period boundaries and graceful stop.

---
 rtl/pwm_gen_pkg.sv | 20 ++
 rtl/pwm_signal_generator_if.sv | 32 +++
 rtl/phase_timer.sv | 26 ++
 rtl/pwm_signal_generator.sv | 138 +++++++++++++
 tb/tb_pwm_signal_generator.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/pwm_gen_pkg.sv
// Shared types for the PWM signal generator: FSM states, default field widths
// and the configuration record held in the active and shadow register sets.
package pwm_gen_pkg;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_BURST_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_CNT_W-1:0]   high;
    logic [DEF_CNT_W-1:0]   low;
    logic [DEF_BURST_W-1:0] cycles;
  } cfg_t;

endpackage

// File: rtl/pwm_signal_generator_if.sv
// Configuration offer channel of the PWM generator (valid/ready with the
// high/low durations and the period count).
interface pwm_signal_generator_if
  import pwm_gen_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) ();

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_high_time;
  logic [CNT_W-1:0]   cfg_low_time;
  logic [BURST_W-1:0] cfg_cycles;

  modport master (
    output cfg_valid,
    output cfg_high_time,
    output cfg_low_time,
    output cfg_cycles,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_high_time,
    input  cfg_low_time,
    input  cfg_cycles,
    output cfg_ready
  );

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase; holds at zero until
// reloaded.
module phase_timer
  import pwm_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pwm_signal_generator.sv
// Programmable square-wave source with finite/continuous bursts, shadowed
// reconfiguration applied at period boundaries and graceful stop.
module pwm_signal_generator
  import pwm_gen_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic                    clk,
  input  logic                    rst,
  pwm_signal_generator_if.slave   cfg,
  input  logic                    stop,
  output logic                    signal_out,
  output logic                    busy,
  output logic                    cycle_done,
  output logic                    burst_done
);

  function automatic logic [CNT_W-1:0] clamp_time(input logic [CNT_W-1:0] t);
    return (t == '0) ? CNT_W'(1) : t;
  endfunction

  state_t             state;
  cfg_t               active;
  cfg_t               shadow;
  cfg_t               cfg_in;
  logic               shadow_valid;
  logic               stop_pending;
  logic [BURST_W-1:0] burst_cnt;

  logic               accept;
  logic               start;
  logic               shadow_load;
  logic               at_boundary;
  logic               last_of_burst;
  logic               end_run;
  logic               promote;
  logic               count_down;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_value;
  logic               tmr_zero;

  assign cfg_in = '{high:   clamp_time(cfg.cfg_high_time),
                    low:    clamp_time(cfg.cfg_low_time),
                    cycles: cfg.cfg_cycles};

  assign cfg.cfg_ready = (state == ST_IDLE) || !shadow_valid;
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign start         = (state == ST_IDLE) && accept;
  assign shadow_load   = (state != ST_IDLE) && accept;

  // Period boundary decisions, in priority order: stop, shadow, burst end.
  assign at_boundary   = (state == ST_LOW) && tmr_zero;
  assign last_of_burst = !shadow_valid && (burst_cnt == BURST_W'(1));
  assign end_run       = stop_pending || last_of_burst;
  assign promote       = at_boundary && !stop_pending && shadow_valid;
  assign count_down    = at_boundary && !stop_pending && !shadow_valid && (burst_cnt > BURST_W'(1));

  assign cycle_done = at_boundary;
  assign burst_done = at_boundary && end_run;

  assign tmr_load  = start || ((state == ST_HIGH) && tmr_zero) || (at_boundary && !end_run);
  assign tmr_value = start              ? cfg_in.high - 1'b1 :
                     (state == ST_HIGH) ? active.low  - 1'b1 :
                     promote            ? shadow.high - 1'b1 :
                                          active.high - 1'b1;

  phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk        (clk),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      signal_out   <= 1'b0;
      busy         <= 1'b0;
      shadow_valid <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_HIGH;
            signal_out <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (accept) shadow_valid <= 1'b1;
          if (stop)   stop_pending <= 1'b1;
          if (tmr_zero) begin
            state      <= ST_LOW;
            signal_out <= 1'b0;
          end
        end
        ST_LOW: begin
          if (accept) shadow_valid <= 1'b1;
          if (stop)   stop_pending <= 1'b1;
          if (tmr_zero) begin
            if (end_run) begin
              // Anything offered on this final cycle is dropped with the run.
              state        <= ST_IDLE;
              busy         <= 1'b0;
              shadow_valid <= 1'b0;
              stop_pending <= 1'b0;
            end else begin
              state      <= ST_HIGH;
              signal_out <= 1'b1;
              if (promote) shadow_valid <= 1'b0;
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          signal_out <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      active    <= cfg_in;
      burst_cnt <= cfg_in.cycles;
    end else if (promote) begin
      active    <= shadow;
      burst_cnt <= shadow.cycles;
    end else if (count_down) begin
      burst_cnt <= burst_cnt - 1'b1;
    end
    if (shadow_load) shadow <= cfg_in;
  end

endmodule

// File: tb/tb_pwm_signal_generator.sv
// Directed and randomized bench for pwm_signal_generator; expected waveforms
// come from a period-by-period model of the high/low/burst rules.
module tb_pwm_signal_generator;
  import pwm_gen_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stop = 1'b0;
  logic signal_out, busy, cycle_done, burst_done;

  int tests = 0;
  int fails = 0;

  pwm_signal_generator_if #(.CNT_W(32), .BURST_W(16)) cfg_if ();

  pwm_signal_generator dut (
    .clk        (clk),
    .rst        (rst),
    .cfg        (cfg_if),
    .stop       (stop),
    .signal_out (signal_out),
    .busy       (busy),
    .cycle_done (cycle_done),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic offer(input int h, input int l, input int n);
    cfg_if.cfg_valid     = 1'b1;
    cfg_if.cfg_high_time = 32'(h);
    cfg_if.cfg_low_time  = 32'(l);
    cfg_if.cfg_cycles    = 16'(n);
  endtask

  task automatic drop();
    cfg_if.cfg_valid = 1'b0;
  endtask

  // hi_n high cycles then lo_n low cycles; cycle_done on the last low cycle.
  task automatic run_cycles(input string tag, input int hi_n, input int lo_n,
                            input bit bd_end, input bit chk_rdy, input bit rdy_exp);
    for (int i = 0; i < hi_n; i++) begin
      chk({tag, "/hi_sig"}, signal_out, 1);
      chk({tag, "/hi_busy"}, busy, 1);
      chk({tag, "/hi_cd"}, cycle_done, 0);
      chk({tag, "/hi_bd"}, burst_done, 0);
      if (chk_rdy) chk({tag, "/hi_rdy"}, cfg_if.cfg_ready, rdy_exp);
      step();
    end
    for (int i = 0; i < lo_n; i++) begin
      chk({tag, "/lo_sig"}, signal_out, 0);
      chk({tag, "/lo_busy"}, busy, 1);
      chk({tag, "/lo_cd"}, cycle_done, (i == lo_n - 1));
      chk({tag, "/lo_bd"}, burst_done, bd_end && (i == lo_n - 1));
      if (chk_rdy) chk({tag, "/lo_rdy"}, cfg_if.cfg_ready, rdy_exp);
      step();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/idle_busy"}, busy, 0);
    chk({tag, "/idle_sig"}, signal_out, 0);
    chk({tag, "/idle_rdy"}, cfg_if.cfg_ready, 1);
    chk({tag, "/idle_cd"}, cycle_done, 0);
    chk({tag, "/idle_bd"}, burst_done, 0);
  endtask

  // Finite burst from IDLE; ends on the first IDLE cycle so the next call is back-to-back.
  task automatic burst(input string tag, input cfg_t c);
    int he, le, n;
    he = (c.high == 0) ? 1 : int'(c.high);
    le = (c.low  == 0) ? 1 : int'(c.low);
    n  = int'(c.cycles);
    chk({tag, "/start_rdy"}, cfg_if.cfg_ready, 1);
    offer(int'(c.high), int'(c.low), n);
    step();
    drop();
    for (int p = 0; p < n; p++) run_cycles(tag, he, le, (p == n - 1), 1'b0, 1'b0);
    chk_idle(tag);
  endtask

  initial begin
    cfg_t c;
    int gap;
    cfg_if.cfg_valid     = 1'b0;
    cfg_if.cfg_high_time = '0;
    cfg_if.cfg_low_time  = '0;
    cfg_if.cfg_cycles    = '0;
    rst = 1'b1;
    step();
    step();
    chk_idle("reset");
    rst = 1'b0;

    c = '{high: 32'd3, low: 32'd2, cycles: 16'd2};
    burst("finite", c);
    c = '{high: 32'd0, low: 32'd0, cycles: 16'd3};
    burst("clamp", c);

    chk("cont/start_rdy", cfg_if.cfg_ready, 1);
    offer(4, 4, 0);
    step();
    drop();
    run_cycles("cont_p1", 4, 4, 1'b0, 1'b1, 1'b1);
    chk("cont_p2/first_sig", signal_out, 1);
    chk("cont_p2/offer_rdy", cfg_if.cfg_ready, 1);
    offer(2, 6, 0);
    step();
    drop();
    run_cycles("cont_p2", 3, 4, 1'b0, 1'b1, 1'b0);
    run_cycles("cont_p3", 2, 6, 1'b0, 1'b1, 1'b1);
    run_cycles("cont_p4", 2, 6, 1'b0, 1'b1, 1'b1);

    chk("rst_mid/pre_sig", signal_out, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("rst_mid");
    step();
    chk_idle("rst_mid2");

    offer(5, 5, 0);
    step();
    drop();
    chk("stop/first_sig", signal_out, 1);
    stop = 1'b1;
    offer(7, 7, 0);
    chk("stop/offer_rdy", cfg_if.cfg_ready, 1);
    step();
    stop = 1'b0;
    drop();
    run_cycles("stop", 4, 5, 1'b1, 1'b1, 1'b0);
    chk_idle("stop_end");
    step();
    step();
    chk_idle("stop_discard");

    for (int k = 0; k < 12; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        chk_idle("rnd_gap");
      end
      c.high   = 32'($urandom_range(0, 6));
      c.low    = 32'($urandom_range(0, 6));
      c.cycles = 16'($urandom_range(1, 3));
      burst("rnd", c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
